// File: rtl/ui_pkg.sv
// Shared user-interface definitions: FSM state encodings and default timing
// constants used by both the button input path and the LED output path.
package ui_pkg;

    typedef enum logic [1:0] {
        StIdle = 2'd0,
        StOn   = 2'd1,
        StGap  = 2'd2
    } ui_state_e;

    // 50 ms at 100 MHz
    localparam int unsigned DefOnCycles   = 5000000;
    localparam int unsigned DefOffCycles  = 5000000;
    localparam int unsigned DefCntBits    = 23;
    localparam int unsigned DefMaxPending = 7;
    localparam int unsigned DefPendBits   = 3;

endpackage

// File: rtl/rise_detect.sv
// Single-bit rising-edge detector: one register plus AND-NOT.
module rise_detect (
    input  logic i_clk,
    input  logic i_reset,
    input  logic i_d,
    output logic o_rise
);

    logic r_q;

    // Delay the input by one cycle. During reset the register tracks the input,
    // so a level that is already high when reset releases is not seen as an edge.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_q <= i_d;
        end else begin
            r_q <= i_d;
        end
    end

    assign o_rise = i_d & ~r_q;

endmodule

// File: rtl/led_pulse_stretcher.sv
// Turns single-cycle events into fixed-length LED blinks separated by a forced
// off-gap. Events that arrive mid-blink are queued in a saturating counter.
module led_pulse_stretcher
    import ui_pkg::*;
#(
    parameter int unsigned ON_CYCLES   = DefOnCycles,
    parameter int unsigned OFF_CYCLES  = DefOffCycles,
    parameter int unsigned CNT_BITS    = DefCntBits,
    parameter int unsigned MAX_PENDING = DefMaxPending,
    parameter int unsigned PEND_BITS   = DefPendBits
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 pulse_in,
    output logic                 led_out,
    output logic                 busy,
    output logic [PEND_BITS-1:0] pending,
    output logic                 overflow
);

    ui_state_e             r_state;
    ui_state_e             w_state_d;
    logic [CNT_BITS-1:0]   r_timer;
    logic [CNT_BITS-1:0]   w_timer_d;
    logic [PEND_BITS-1:0]  r_pending;
    logic [PEND_BITS-1:0]  w_pending_d;
    logic                  r_overflow;
    logic                  w_overflow_d;
    logic                  r_led;
    logic                  w_led_d;
    logic                  r_busy;
    logic                  w_busy_d;

    logic                  w_event;
    logic                  w_last_on;
    logic                  w_last_gap;
    logic                  w_q_full;
    logic                  w_q_empty;

    rise_detect u_rise_detect (
        .i_clk   (clk),
        .i_reset (reset),
        .i_d     (pulse_in),
        .o_rise  (w_event)
    );

    assign w_last_on  = (r_timer == CNT_BITS'(ON_CYCLES - 1));
    assign w_last_gap = (r_timer == CNT_BITS'(OFF_CYCLES - 1));
    assign w_q_full   = (r_pending == PEND_BITS'(MAX_PENDING));
    assign w_q_empty  = (r_pending == '0);

    // State, timer, queue and registered outputs.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state    <= StIdle;
            r_timer    <= '0;
            r_pending  <= '0;
            r_overflow <= 1'b0;
            r_led      <= 1'b0;
            r_busy     <= 1'b0;
        end else begin
            r_state    <= w_state_d;
            r_timer    <= w_timer_d;
            r_pending  <= w_pending_d;
            r_overflow <= w_overflow_d;
            r_led      <= w_led_d;
            r_busy     <= w_busy_d;
        end
    end

    // Next-state, timer and queue accounting.
    always_comb begin
        w_state_d    = r_state;
        w_timer_d    = r_timer;
        w_pending_d  = r_pending;
        w_overflow_d = r_overflow;

        unique case (r_state)
            StIdle: begin
                if (w_event) begin
                    w_state_d = StOn;
                    w_timer_d = '0;
                end
            end
            StOn: begin
                if (w_last_on) begin
                    w_state_d = StGap;
                    w_timer_d = '0;
                end else begin
                    w_timer_d = r_timer + CNT_BITS'(1);
                end
                if (w_event) begin
                    if (w_q_full) w_overflow_d = 1'b1;
                    else          w_pending_d  = r_pending + PEND_BITS'(1);
                end
            end
            StGap: begin
                if (w_last_gap) begin
                    w_timer_d = '0;
                    // An event on the exit cycle either starts the next blink
                    // itself or cancels against the dequeue.
                    if (!w_q_empty || w_event) begin
                        w_state_d = StOn;
                        if (!w_q_empty && !w_event) begin
                            w_pending_d = r_pending - PEND_BITS'(1);
                        end
                    end else begin
                        w_state_d = StIdle;
                    end
                end else begin
                    w_timer_d = r_timer + CNT_BITS'(1);
                    if (w_event) begin
                        if (w_q_full) w_overflow_d = 1'b1;
                        else          w_pending_d  = r_pending + PEND_BITS'(1);
                    end
                end
            end
            default: begin
                w_state_d = StIdle;
                w_timer_d = '0;
            end
        endcase
    end

    // Outputs decoded from the next state so they land in registers.
    always_comb begin
        w_led_d  = (w_state_d == StOn);
        w_busy_d = (w_state_d != StIdle);
    end

    assign led_out  = r_led;
    assign busy     = r_busy;
    assign pending  = r_pending;
    assign overflow = r_overflow;

endmodule

// File: tb/tb_led_pulse_stretcher.sv
// Directed bench for led_pulse_stretcher with ON=3, OFF=2, MAX_PENDING=3.
// Each trace character i is pulse_in before clock edge i and the expected
// outputs sampled 1 ns after that edge.
module tb_led_pulse_stretcher;

    logic       clk;
    logic       reset;
    logic       pulse_in;
    logic       led_out;
    logic       busy;
    logic [1:0] pending;
    logic       overflow;

    int n_checks = 0;
    int n_pass   = 0;

    led_pulse_stretcher #(
        .ON_CYCLES   (3),
        .OFF_CYCLES  (2),
        .CNT_BITS    (2),
        .MAX_PENDING (3),
        .PEND_BITS   (2)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .pulse_in (pulse_in),
        .led_out  (led_out),
        .busy     (busy),
        .pending  (pending),
        .overflow (overflow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input int idx, input logic [1:0] obs,
                         input logic [1:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s[%0d] observed=%0d expected=%0d", tag, idx, obs, exp);
    endtask

    task automatic check_idle(input string tag);
        check({tag, ".led"},  0, {1'b0, led_out},  2'd0);
        check({tag, ".busy"}, 0, {1'b0, busy},     2'd0);
        check({tag, ".pend"}, 0, pending,          2'd0);
        check({tag, ".ovf"},  0, {1'b0, overflow}, 2'd0);
    endtask

    task automatic do_reset();
        pulse_in = 1'b0;
        reset    = 1'b1;
        step();
        reset    = 1'b0;
    endtask

    task automatic trace(input string tag, input string pul, input string led,
                         input string bsy, input string pnd, input string ovf);
        for (int i = 0; i < pul.len(); i++) begin
            pulse_in = (pul[i] == "1");
            step();
            check({tag, ".led"},  i, {1'b0, led_out},  {1'b0, led[i] == "1"});
            check({tag, ".busy"}, i, {1'b0, busy},     {1'b0, bsy[i] == "1"});
            check({tag, ".pend"}, i, pending,          2'(int'(pnd[i]) - 48));
            check({tag, ".ovf"},  i, {1'b0, overflow}, {1'b0, ovf[i] == "1"});
        end
        pulse_in = 1'b0;
    endtask

    string s3_pul = "10101010101010000000000000000000";
    string s3_led = "11100111001110011100111001110000";
    string s3_bsy = "11111111111111111111111111111100";
    string s3_pnd = "00112122333333322222111110000000";
    string s3_ovf = "00000000000011111111111111111111";

    initial begin
        pulse_in = 1'b0;
        reset    = 1'b1;
        step();
        step();
        check_idle("reset");
        reset = 1'b0;
        step();
        check_idle("idle");

        // Single pulse: 3 on, 2 gap, then idle.
        trace("single", "100000", "111000", "111110", "000000", "000000");

        // Queued events drain one per gap exit with no idle cycle between blinks.
        do_reset();
        trace("queue",
              "1010101000000000000000",
              "1110011100111001110000",
              "1111111111111111111100",
              "0011212222111110000000",
              "0000000000000000000000");

        // Saturation at 3 pending, dropped event sets sticky overflow.
        do_reset();
        trace("sat", s3_pul, s3_led, s3_bsy, s3_pnd, s3_ovf);

        // Event on the last gap cycle with nothing pending starts a blink directly.
        do_reset();
        trace("gapexit", "10000100000", "11100111000", "11111111110",
              "00000000000", "00000000000");

        // A level held high is a single event.
        do_reset();
        trace("held", "111111111100", "111000000000", "111110000000",
              "000000000000", "000000000000");

        // Reset mid-ON with pending=2 and overflow=1.
        do_reset();
        trace("prerst", s3_pul.substr(0, 16), s3_led.substr(0, 16), s3_bsy.substr(0, 16),
              s3_pnd.substr(0, 16), s3_ovf.substr(0, 16));
        reset = 1'b1;
        step();
        reset = 1'b0;
        check_idle("midrst");
        trace("postrst", "100000", "111000", "111110", "000000", "000000");

        // pulse_in high across reset release is not an event.
        reset    = 1'b1;
        pulse_in = 1'b1;
        step();
        reset = 1'b0;
        step();
        step();
        check_idle("hirst");
        pulse_in = 1'b0;
        step();
        check_idle("hirst_low");

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
